data_mem_mmio: RTL and testbench
================================

// Module: data_mem_mmio
// PURPOSE
//  Responder end of the single-cycle core's data-memory port: word RAM plus a small MMIO window.
//  Reads answer combinationally (same cycle, as the core requires); writes commit on the rising clk edge.
//  MMIO exposes a cycle counter and an output stream FIFO (valid/ready) drained by the testbench or a peripheral.
// PARAMETERS
//  DEPTH_WORDS  64            RAM words; power of 2
//  FIFO_DEPTH   8             output FIFO entries; power of 2, >=2
//  MMIO_BASE    32'hFFFF_0000 MMIO decoded when dmem_addr[31:16]==MMIO_BASE[31:16]
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  dmem_we     in   1   write strobe from core
//  dmem_addr   in   32  byte address (ALU result)
//  dmem_wdata  in   32  store data
//  dmem_rdata  out  32  load data, combinational from dmem_addr
//  out_valid   out  1   FIFO head valid
//  out_data    out  32  FIFO head word
//  out_ready   in   1   consumer accepts head when out_valid&out_ready
// BEHAVIOUR
//  Reset: FIFO empty (out_valid=0, out_data=0), cycle counter=0, overflow flag=0. RAM contents NOT reset.
//  RAM: index = dmem_addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored; higher bits outside MMIO alias (wrap).
//  MMIO offsets (dmem_addr[15:0]):
//   0x0 OUT_DATA  W: push dmem_wdata into FIFO.  R: {28'b0, count} (count 0..FIFO_DEPTH, zero-extended).
//   0x4 STATUS    R: {29'b0, overflow, full, empty}. W with wdata[2]=1 clears overflow.
//   0x8 CYCLE     R: free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF->0. W: loads 0.
//   other         R: 0. W: ignored, no side effects.
//  MMIO writes never touch RAM; RAM writes never touch MMIO.
//  Counter: a CYCLE write wins over increment that cycle (value 0 after edge, 1 one cycle later).
//  FIFO push: write to OUT_DATA; if full (pre-pop count==FIFO_DEPTH) word dropped and overflow set
//   sticky, even if a pop occurs the same cycle.
//  FIFO pop: out_valid&out_ready; head advances at edge.
//  Push+pop same cycle, not full: count unchanged, both take effect.
//  No bypass: push into empty FIFO -> out_valid=1 the following cycle.
//  out_data holds head value while out_valid=1 and not popped; out_valid=0 -> out_data=0.
//  Overflow set and clear in same cycle: set wins.
//  STATUS read reflects pre-edge state (combinational from registers).
//  Pointers wrap modulo FIFO_DEPTH; count uses log2(FIFO_DEPTH)+1 bits.
//  rst asserted mid-stream: FIFO flushed, counter/flag cleared immediately (async); RAM retained.
// STRUCTURE
//  Package mips_mem_pkg: MMIO_BASE_HI, OFF_OUT_DATA=16'h0, OFF_STATUS=16'h4, OFF_CYCLE=16'h8, STATUS bit indices.
//  Sub-module stream_fifo (params WIDTH, DEPTH; push/full, pop/empty, count, overflow-free core);
//   overflow flag and address decode stay in data_mem_mmio.
// TESTING
//  RAM: write 0xDEADBEEF @0x10, read 0x10 and 0x13 -> 0xDEADBEEF; read 0x10+4*DEPTH_WORDS -> aliases, 0xDEADBEEF.
//  Reset: drive rst mid-run after 3 pushes -> out_valid=0, STATUS=0x1, CYCLE reads 0 next cycle; RAM word still 0xDEADBEEF.
//  FIFO fill: out_ready=0, push 1..9 -> STATUS=0x6 (full+overflow), count=8; drain -> out_data 1..8 in order, 9 absent.
//  Push+pop: 1 entry queued, out_ready=1, push 0xA5 -> count stays 1, next out_data=0xA5; push into full with pop -> dropped, overflow=1.
//  Overflow clear: write STATUS 0x4 -> STATUS bit2=0; same-cycle overflow push + clear -> bit2=1.
//  Counter: write CYCLE, read after 5 cycles -> 5; force wrap from 0xFFFF_FFFF -> 0; unmapped offset 0x20 read -> 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the core's data-memory port and its MMIO window.
package mips_mem_pkg;

    localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

    localparam logic [15:0] OFF_OUT_DATA = 16'h0000;
    localparam logic [15:0] OFF_STATUS   = 16'h0004;
    localparam logic [15:0] OFF_CYCLE    = 16'h0008;

    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_OVF_BIT   = 2;

    typedef enum logic [1:0] {
        MMIO_OUT_DATA = 2'd0,
        MMIO_STATUS   = 2'd1,
        MMIO_CYCLE    = 2'd2,
        MMIO_NONE     = 2'd3
    } mmio_reg_e;

    typedef struct packed {
        logic [28:0] rsvd;
        logic        overflow;
        logic        full;
        logic        empty;
    } status_t;

    // Map a 16-bit MMIO offset onto the register it selects.
    function automatic mmio_reg_e decode_offset(input logic [15:0] off);
        mmio_reg_e sel;
        case (off)
            OFF_OUT_DATA: sel = MMIO_OUT_DATA;
            OFF_STATUS:   sel = MMIO_STATUS;
            OFF_CYCLE:    sel = MMIO_CYCLE;
            default:      sel = MMIO_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO core: pushes into a full FIFO and pops from an empty one are ignored.
module stream_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       full_o,
    input  logic                       pop_i,
    output logic                       empty_o,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at a power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-memory responder: word RAM with combinational reads plus an MMIO window
// holding an output stream FIFO, its sticky overflow flag and a cycle counter.
module data_mem_mmio
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = {MMIO_BASE_HI, 16'h0000}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_q [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;

    logic          is_mmio;
    mmio_reg_e     reg_sel;
    logic          wr_ram, wr_out, wr_status, wr_cycle;

    logic          fifo_full, fifo_empty, fifo_pop;
    logic [31:0]   fifo_head;
    logic [CW-1:0] fifo_count;

    logic          overflow_q, overflow_d;
    logic [31:0]   cycle_q, cycle_d;

    // Address decode: MMIO window by upper half-word, RAM aliases everywhere else.
    always_comb begin
        is_mmio   = (dmem_addr[31:16] == MMIO_BASE[31:16]);
        reg_sel   = decode_offset(dmem_addr[15:0]);
        ram_idx   = dmem_addr[AW+1:2];
        wr_ram    = dmem_we && !is_mmio;
        wr_out    = dmem_we && is_mmio && (reg_sel == MMIO_OUT_DATA);
        wr_status = dmem_we && is_mmio && (reg_sel == MMIO_STATUS);
        wr_cycle  = dmem_we && is_mmio && (reg_sel == MMIO_CYCLE);
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;
    assign fifo_pop  = out_valid && out_ready;

    stream_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_out),
        .data_i  (dmem_wdata),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .empty_o (fifo_empty),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    // Overflow flag and cycle counter next-state; overflow set beats a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        cycle_d    = cycle_q + 32'd1;
        if (wr_status && dmem_wdata[STATUS_OVF_BIT]) begin
            overflow_d = 1'b0;
        end
        if (wr_out && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (wr_cycle) begin
            cycle_d = '0;
        end
    end

    // MMIO state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            cycle_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram_q[ram_idx] <= dmem_wdata;
        end
    end

    // Combinational read mux: RAM word or MMIO register image.
    always_comb begin
        status_t st;
        st          = '0;
        st.overflow = overflow_q;
        st.full     = fifo_full;
        st.empty    = fifo_empty;
        dmem_rdata  = '0;
        if (is_mmio) begin
            case (reg_sel)
                MMIO_OUT_DATA: dmem_rdata = 32'(fifo_count);
                MMIO_STATUS:   dmem_rdata = st;
                MMIO_CYCLE:    dmem_rdata = cycle_q;
                default:       dmem_rdata = '0;
            endcase
        end else begin
            dmem_rdata = ram_q[ram_idx];
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: RAM aliasing, MMIO registers, FIFO ordering/overflow, reset.
module tb_data_mem_mmio;

    localparam logic [31:0] A_OUT    = 32'hFFFF_0000;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
    localparam logic [31:0] A_UNMAP  = 32'hFFFF_0020;

    logic        clk;
    logic        rst;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_mmio #(
        .DEPTH_WORDS (64),
        .FIFO_DEPTH  (8),
        .MMIO_BASE   (32'hFFFF_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        dmem_we    = 1'b1;
        dmem_addr  = addr;
        dmem_wdata = data;
        tick();
        dmem_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        dmem_addr = addr;
        #1;
        data = dmem_rdata;
    endtask

    initial begin
        logic [31:0] v;

        rst        = 1'b1;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        out_ready  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", out_data, 32'd0);
        rd(A_STATUS, v); check_eq("rst_status", v, 32'h1);
        rd(A_OUT, v);    check_eq("rst_count", v, 32'd0);

        // RAM write/read, byte offset ignored, aliasing above the array
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, v); check_eq("ram_rd", v, 32'hDEAD_BEEF);
        rd(32'h0000_0013, v); check_eq("ram_rd_byteoff", v, 32'hDEAD_BEEF);
        rd(32'h0000_0110, v); check_eq("ram_alias", v, 32'hDEAD_BEEF);

        // MMIO writes leave RAM alone, unmapped offset reads 0
        wr(32'hFFFF_0010, 32'h1234_5678);
        rd(32'h0000_0010, v); check_eq("mmio_no_ram", v, 32'hDEAD_BEEF);
        rd(A_UNMAP, v);       check_eq("unmapped_rd", v, 32'd0);
        rd(A_STATUS, v);      check_eq("unmapped_wr_status", v, 32'h1);

        // Cycle counter load and count
        wr(A_CYCLE, 32'hFFFF_FFFF);
        rd(A_CYCLE, v); check_eq("cycle_load", v, 32'd0);
        repeat (5) tick();
        rd(A_CYCLE, v); check_eq("cycle_5", v, 32'd5);

        // No bypass: head not visible during the push cycle
        dmem_we = 1'b1; dmem_addr = A_OUT; dmem_wdata = 32'd1;
        #1;
        check_eq("no_bypass", 32'(out_valid), 32'd0);
        tick();
        dmem_we = 1'b0;
        check_eq("push_visible", 32'(out_valid), 32'd1);

        // Fill beyond capacity with no consumer
        for (int i = 2; i <= 9; i++) begin
            wr(A_OUT, 32'(i));
        end
        rd(A_STATUS, v); check_eq("fill_status", v, 32'h6);
        rd(A_OUT, v);    check_eq("fill_count", v, 32'd8);
        check_eq("fill_head", out_data, 32'd1);

        // Drain in order; the dropped 9 must not appear
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_eq($sformatf("drain_%0d", i), out_data, 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check_eq("drain_empty_valid", 32'(out_valid), 32'd0);
        check_eq("drain_empty_data", out_data, 32'd0);
        rd(A_STATUS, v); check_eq("drain_status", v, 32'h5);

        // Overflow clear only with bit2 set
        wr(A_STATUS, 32'h3);
        rd(A_STATUS, v); check_eq("ovf_no_clear", v, 32'h5);
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, v); check_eq("ovf_clear", v, 32'h1);

        // Push and pop in one cycle with one entry queued
        wr(A_OUT, 32'h11);
        out_ready = 1'b1;
        wr(A_OUT, 32'hA5);
        out_ready = 1'b0;
        rd(A_OUT, v); check_eq("pushpop_count", v, 32'd1);
        check_eq("pushpop_head", out_data, 32'hA5);

        // Push into full with a same-cycle pop: word dropped, overflow set
        for (int i = 1; i <= 7; i++) begin
            wr(A_OUT, 32'h20 + 32'(i));
        end
        rd(A_STATUS, v); check_eq("full_again", v, 32'h2);
        out_ready = 1'b1;
        wr(A_OUT, 32'hBB);
        out_ready = 1'b0;
        rd(A_STATUS, v); check_eq("full_pop_ovf", v, 32'h4);
        rd(A_OUT, v);    check_eq("full_pop_count", v, 32'd7);
        out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            check_eq($sformatf("drain2_%0d", i), out_data, 32'h20 + 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check_eq("drain2_empty", 32'(out_valid), 32'd0);
        wr(A_STATUS, 32'h4);

        // Asynchronous reset mid-stream after three pushes
        for (int i = 1; i <= 3; i++) begin
            wr(A_OUT, 32'h40 + 32'(i));
        end
        rd(A_OUT, v); check_eq("pre_rst_count", v, 32'd3);
        rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        rd(A_STATUS, v); check_eq("arst_status", v, 32'h1);
        rd(A_CYCLE, v);  check_eq("arst_cycle", v, 32'd0);
        tick();
        rst = 1'b0;
        rd(A_CYCLE, v); check_eq("post_rst_cycle", v, 32'd0);
        tick();
        rd(A_CYCLE, v); check_eq("post_rst_cycle1", v, 32'd1);
        rd(32'h0000_0010, v); check_eq("ram_retained", v, 32'hDEAD_BEEF);
        check_eq("post_rst_data", out_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
